// File: rtl/dec_pkg.sv
// Shared opcode map, FSM state type and small decode helpers for the TB4004 instruction decoder.
package dec_pkg;

    // Upper nibble (OPR) opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;  // FIM when opa[0]=0, SRC when opa[0]=1
    localparam logic [3:0] OP_FIN = 4'h3;
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_XCH = 4'hB;
    localparam logic [3:0] OP_BBL = 4'hC;
    localparam logic [3:0] OP_LDM = 4'hD;
    localparam logic [3:0] OP_IO  = 4'hE;
    localparam logic [3:0] OP_ACC = 4'hF;

    // Accumulator group (OPR=F), selected by OPA
    localparam logic [3:0] FN_CLB = 4'h0;
    localparam logic [3:0] FN_CLC = 4'h1;
    localparam logic [3:0] FN_IAC = 4'h2;
    localparam logic [3:0] FN_CMC = 4'h3;
    localparam logic [3:0] FN_CMA = 4'h4;
    localparam logic [3:0] FN_RAL = 4'h5;
    localparam logic [3:0] FN_RAR = 4'h6;
    localparam logic [3:0] FN_TCC = 4'h7;
    localparam logic [3:0] FN_DAC = 4'h8;
    localparam logic [3:0] FN_TCS = 4'h9;
    localparam logic [3:0] FN_STC = 4'hA;
    localparam logic [3:0] FN_DAA = 4'hB;
    localparam logic [3:0] FN_KBP = 4'hC;
    localparam logic [3:0] FN_DCL = 4'hD;

    localparam int ALU_OP_W = 5;

    typedef enum logic {
        S_WORD1 = 1'b0,
        S_WORD2 = 1'b1
    } state_t;

    function automatic logic two_word(input logic [3:0] op_r, input logic [3:0] op_a);
        return (op_r == OP_JCN) || (op_r == OP_FIM && !op_a[0]) ||
               (op_r == OP_JUN) || (op_r == OP_JMS) || (op_r == OP_ISZ);
    endfunction

    function automatic logic uses_alu(input logic [3:0] op_r);
        case (op_r)
            OP_INC, OP_ISZ, OP_ADD, OP_SUB, OP_LD, OP_XCH, OP_LDM, OP_ACC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_op_enc(input logic [3:0] op_r, input logic [3:0] op_a);
        return (op_r == OP_ACC) ? {1'b1, op_a} : {1'b0, op_r};
    endfunction

endpackage

// File: rtl/dec_test_sync.sv
// Reset-to-zero flop chain used to bring the asynchronous TEST pin into the clk domain.
module dec_test_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/instr_decoder_cc_seq.sv
// TB4004 instruction decoder and condition-code unit: latches OPR/OPA, sequences 1-/2-word
// instructions, owns carry/zero/test flags. Macro DEC_TEST_SYNC_EN selects a deep TEST synchroniser.
module instr_decoder_cc_seq
    import dec_pkg::*;
#(
    parameter int CYCLE_W       = 3,
    parameter int OPR_CYCLE     = 3,
    parameter int OPA_CYCLE     = 4,
    parameter int EXEC_CYCLE    = 7,
    parameter int TEST_SYNC_STG = 2
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [3:0]         opr,
    input  logic [3:0]         opa,
    input  logic [CYCLE_W-1:0] cycle,
    input  logic               carryFromAlu,
    input  logic               zeroFromAlu,
    input  logic               testIn,
    output logic               aluEnable,
    output logic [4:0]         aluOp,
    output logic               accWe,
    output logic               tempWe,
    output logic               carryFlag,
    output logic               zeroFlag,
    output logic               testFlag,
    output logic               condTrue,
    output logic               secondWord,
    output logic               operandWe,
    output logic               jumpLoad
);

    localparam logic [CYCLE_W-1:0] OPR_C  = CYCLE_W'(OPR_CYCLE);
    localparam logic [CYCLE_W-1:0] OPA_C  = CYCLE_W'(OPA_CYCLE);
    localparam logic [CYCLE_W-1:0] EXEC_C = CYCLE_W'(EXEC_CYCLE);

`ifdef DEC_TEST_SYNC_EN
    localparam int SYNC_STAGES = TEST_SYNC_STG;
`else
    // Depth is only meaningful with the synchroniser enabled; otherwise a single sample flop.
    localparam int SYNC_STAGES = 1 + 0 * TEST_SYNC_STG;
`endif

    state_t                state, state_nxt;
    logic [3:0]            ir_opr, ir_opa;
    logic                  carry, zero;
    logic                  cond_latched, isz_zero;
    logic                  carry_nxt, zero_nxt, cond_nxt, isz_nxt;
    logic                  acc_we_nxt, temp_we_nxt, operand_we_nxt, jump_load_nxt;
    logic                  alu_en_nxt;
    logic [ALU_OP_W-1:0]   alu_op_nxt;
    logic                  test_flag;

    dec_test_sync #(.STAGES(SYNC_STAGES)) u_test_sync (
        .clk  (clk),
        .rstN (rstN),
        .d    (testIn),
        .q    (test_flag)
    );

    // Flags seen here are the registered (pre-update) values.
    assign condTrue   = ((~test_flag & ir_opa[0]) | (carry & ir_opa[1]) | (zero & ir_opa[2])) ^ ir_opa[3];
    assign carryFlag  = carry;
    assign zeroFlag   = zero;
    assign testFlag   = test_flag;
    assign secondWord = (state == S_WORD2);

    always_comb begin
        state_nxt      = state;
        carry_nxt      = carry;
        zero_nxt       = zero;
        cond_nxt       = cond_latched;
        isz_nxt        = isz_zero;
        acc_we_nxt     = 1'b0;
        temp_we_nxt    = 1'b0;
        operand_we_nxt = 1'b0;
        jump_load_nxt  = 1'b0;
        alu_en_nxt     = 1'b0;
        alu_op_nxt     = '0;
        case (state)
            S_WORD1: begin
                if (cycle > OPA_C && uses_alu(ir_opr)) begin
                    alu_en_nxt = 1'b1;
                    alu_op_nxt = alu_op_enc(ir_opr, ir_opa);
                end
                if (cycle == EXEC_C) begin
                    case (ir_opr)
                        OP_ADD, OP_SUB: begin
                            acc_we_nxt = 1'b1;
                            carry_nxt  = carryFromAlu;
                        end
                        OP_LD, OP_LDM: acc_we_nxt = 1'b1;
                        OP_XCH: begin
                            acc_we_nxt  = 1'b1;
                            temp_we_nxt = 1'b1;
                        end
                        OP_INC: temp_we_nxt = 1'b1;
                        OP_ISZ: begin
                            temp_we_nxt = 1'b1;
                            isz_nxt     = zeroFromAlu;
                        end
                        OP_JCN: cond_nxt = condTrue;
                        OP_ACC: begin
                            case (ir_opa)
                                FN_CLB, FN_TCC, FN_TCS: begin
                                    acc_we_nxt = 1'b1;
                                    carry_nxt  = 1'b0;
                                end
                                FN_IAC, FN_DAC, FN_RAL, FN_RAR, FN_DAA: begin
                                    acc_we_nxt = 1'b1;
                                    carry_nxt  = carryFromAlu;
                                end
                                FN_CMA, FN_KBP: acc_we_nxt = 1'b1;
                                FN_CLC: carry_nxt = 1'b0;
                                FN_STC: carry_nxt = 1'b1;
                                FN_CMC: carry_nxt = ~carry;
                                FN_DCL: ;
                                default: ;
                            endcase
                        end
                        OP_NOP, OP_FIM, OP_FIN, OP_JUN, OP_JMS, OP_BBL, OP_IO: ;
                        default: ;
                    endcase
                    if (acc_we_nxt) begin
                        zero_nxt = zeroFromAlu;
                    end
                    if (two_word(ir_opr, ir_opa)) begin
                        state_nxt = S_WORD2;
                    end
                end
            end
            S_WORD2: begin
                operand_we_nxt = (cycle == OPA_C);
                if (cycle == EXEC_C) begin
                    case (ir_opr)
                        OP_JUN, OP_JMS: jump_load_nxt = 1'b1;
                        OP_JCN:         jump_load_nxt = cond_latched;
                        OP_ISZ:         jump_load_nxt = ~isz_zero;
                        default:        jump_load_nxt = 1'b0;
                    endcase
                    state_nxt = S_WORD1;
                end
            end
            default: state_nxt = S_WORD1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= S_WORD1;
            ir_opr       <= '0;
            ir_opa       <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            cond_latched <= 1'b0;
            isz_zero     <= 1'b0;
            aluEnable    <= 1'b0;
            aluOp        <= '0;
            accWe        <= 1'b0;
            tempWe       <= 1'b0;
            operandWe    <= 1'b0;
            jumpLoad     <= 1'b0;
        end else begin
            state        <= state_nxt;
            // The second word is an operand byte: it never overwrites the instruction register.
            if (state == S_WORD1 && cycle == OPR_C) ir_opr <= opr;
            if (state == S_WORD1 && cycle == OPA_C) ir_opa <= opa;
            carry        <= carry_nxt;
            zero         <= zero_nxt;
            cond_latched <= cond_nxt;
            isz_zero     <= isz_nxt;
            aluEnable    <= alu_en_nxt;
            aluOp        <= alu_op_nxt;
            accWe        <= acc_we_nxt;
            tempWe       <= temp_we_nxt;
            operandWe    <= operand_we_nxt;
            jumpLoad     <= jump_load_nxt;
        end
    end

endmodule

// File: tb/tb_instr_decoder_cc_seq.sv
// Self-checking bench for instr_decoder_cc_seq; strobes are scored against an expected queue.
module tb_instr_decoder_cc_seq;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] opr, opa;
    logic [2:0] cycle;
    logic       carryFromAlu, zeroFromAlu, testIn;
    logic       aluEnable, accWe, tempWe, carryFlag, zeroFlag, testFlag;
    logic       condTrue, secondWord, operandWe, jumpLoad;
    logic [4:0] aluOp;

    int checks = 0;
    int errors = 0;

    // Strobe vector {accWe, tempWe, operandWe, jumpLoad}
    logic [3:0] exp_q[$];
    logic [3:0] mon_got, mon_exp;
    bit         mon_en = 1'b0;

    logic [7:0] alu_tr, sw_tr, cond_tr;

    logic [3:0] fn_tab [5] = '{4'hA, 4'h3, 4'h1, 4'h3, 4'h1};
    logic       cy_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    instr_decoder_cc_seq dut (
        .clk          (clk),
        .rstN         (rstN),
        .opr          (opr),
        .opa          (opa),
        .cycle        (cycle),
        .carryFromAlu (carryFromAlu),
        .zeroFromAlu  (zeroFromAlu),
        .testIn       (testIn),
        .aluEnable    (aluEnable),
        .aluOp        (aluOp),
        .accWe        (accWe),
        .tempWe       (tempWe),
        .carryFlag    (carryFlag),
        .zeroFlag     (zeroFlag),
        .testFlag     (testFlag),
        .condTrue     (condTrue),
        .secondWord   (secondWord),
        .operandWe    (operandWe),
        .jumpLoad     (jumpLoad)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #1;
        mon_got = {accWe, tempWe, operandWe, jumpLoad};
        if (mon_en && mon_got !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got=%b required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe got=%b required=%b", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic step(input logic [2:0] c);
        cycle = c;
        @(posedge clk);
        #1;
    endtask

    // One 8-clock instruction word; testIn takes t_late from cycle 6 on.
    task automatic run_word(input logic [3:0] o, input logic [3:0] a,
                            input logic cf, input logic zf, input logic t_late);
        for (int c = 0; c < 8; c++) begin
            opr = o;
            opa = a;
            carryFromAlu = cf;
            zeroFromAlu = zf;
            if (c == 6) testIn = t_late;
            step(3'(c));
            alu_tr[c]  = aluEnable;
            sw_tr[c]   = secondWord;
            cond_tr[c] = condTrue;
        end
    endtask

    task automatic test_reset;
        logic jl_seen;
        rstN = 1'b0;
        opr = '0; opa = '0; carryFromAlu = 1'b0; zeroFromAlu = 1'b0; testIn = 1'b0;
        repeat (3) step(3'd0);
        checks++;
        if ({aluEnable, aluOp, accWe, tempWe, carryFlag, zeroFlag, testFlag, condTrue,
             secondWord, operandWe, jumpLoad} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0", {aluEnable, aluOp, accWe, tempWe,
                     carryFlag, zeroFlag, testFlag, condTrue, secondWord, operandWe, jumpLoad});
        end
        rstN = 1'b1;
        mon_en = 1'b1;
        // Reset in the middle of a JUN second word
        run_word(4'h4, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sw_tr[7] !== 1'b1) begin
            errors++;
            $display("FAIL jun_enter_word2 got=%b required=1", sw_tr[7]);
        end
        exp_q.push_back(4'b0010);
        opr = 4'h3; opa = 4'h7;
        for (int c = 0; c < 5; c++) step(3'(c));
        rstN = 1'b0;
        step(3'd5);
        rstN = 1'b1;
        checks++;
        if (secondWord !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_jun_secondword got=%b required=0", secondWord);
        end
        opr = '0; opa = '0;
        jl_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(3'((6 + i) % 8));
            jl_seen = jl_seen | jumpLoad;
        end
        checks++;
        if (jl_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_jun_jumpload got=%b required=0", jl_seen);
        end
    endtask

    task automatic test_alu_ops;
        exp_q.push_back(4'b1000);
        run_word(4'h8, 4'h3, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({carryFlag, zeroFlag} !== 2'b10) begin
            errors++;
            $display("FAIL add_flags got=%b required=10", {carryFlag, zeroFlag});
        end
        checks++;
        if (alu_tr !== 8'hE0) begin
            errors++;
            $display("FAIL add_alu_enable got=%h required=e0", alu_tr);
        end
        checks++;
        if (aluOp !== 5'h08) begin
            errors++;
            $display("FAIL add_alu_op got=%h required=08", aluOp);
        end
        exp_q.push_back(4'b1000);
        run_word(4'h9, 4'h5, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({carryFlag, zeroFlag} !== 2'b01) begin
            errors++;
            $display("FAIL sub_flags got=%b required=01", {carryFlag, zeroFlag});
        end
        // LD writes acc and zero but leaves carry alone
        exp_q.push_back(4'b1000);
        run_word(4'hA, 4'h2, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({carryFlag, zeroFlag} !== 2'b00) begin
            errors++;
            $display("FAIL ld_flags got=%b required=00", {carryFlag, zeroFlag});
        end
    endtask

    task automatic test_carry_ops;
        for (int i = 0; i < 5; i++) begin
            run_word(4'hF, fn_tab[i], ~cy_tab[i], 1'b1, 1'b0);
            checks++;
            if (carryFlag !== cy_tab[i] || zeroFlag !== 1'b0) begin
                errors++;
                $display("FAIL carry_op_%0d got=%b%b required=%b0", i, carryFlag, zeroFlag, cy_tab[i]);
            end
        end
        run_word(4'hF, 4'hA, 1'b0, 1'b0, 1'b0);
        checks++;
        if (aluOp !== 5'h1A || alu_tr !== 8'hE0) begin
            errors++;
            $display("FAIL stc_alu got=%h/%h required=1a/e0", aluOp, alu_tr);
        end
        exp_q.push_back(4'b1000);
        run_word(4'hF, 4'h7, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({carryFlag, zeroFlag} !== 2'b01) begin
            errors++;
            $display("FAIL tcc_flags got=%b required=01", {carryFlag, zeroFlag});
        end
        exp_q.push_back(4'b1000);
        run_word(4'hF, 4'h2, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({carryFlag, zeroFlag} !== 2'b10) begin
            errors++;
            $display("FAIL iac_flags got=%b required=10", {carryFlag, zeroFlag});
        end
    endtask

    task automatic test_jcn_flags;
        run_word(4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cond_tr[7] !== 1'b1 || sw_tr[7] !== 1'b1) begin
            errors++;
            $display("FAIL jcn_c_cond got=%b/%b required=1/1", cond_tr[7], sw_tr[7]);
        end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        run_word(4'h3, 4'hC, 1'b0, 1'b0, 1'b0);
        checks++;
        if (secondWord !== 1'b0) begin
            errors++;
            $display("FAIL jcn_back_word1 got=%b required=0", secondWord);
        end
        run_word(4'h1, 4'hA, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cond_tr[7] !== 1'b0) begin
            errors++;
            $display("FAIL jcn_nc_cond got=%b required=0", cond_tr[7]);
        end
        exp_q.push_back(4'b0010);
        run_word(4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_jcn_test_pin;
        logic exp_t;
        testIn = 1'b1;
        step(3'd0);
`ifdef DEC_TEST_SYNC_EN
        exp_t = 1'b0;
`else
        exp_t = 1'b1;
`endif
        checks++;
        if (testFlag !== exp_t) begin
            errors++;
            $display("FAIL test_lag_1 got=%b required=%b", testFlag, exp_t);
        end
        step(3'd0);
        checks++;
        if (testFlag !== 1'b1) begin
            errors++;
            $display("FAIL test_lag_2 got=%b required=1", testFlag);
        end
        run_word(4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cond_tr[7] !== 1'b0) begin
            errors++;
            $display("FAIL jcn_t_high_cond got=%b required=0", cond_tr[7]);
        end
        exp_q.push_back(4'b0010);
        run_word(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        // testIn falls one clk before X3
        run_word(4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cond_tr[5] !== 1'b0) begin
            errors++;
            $display("FAIL jcn_late_pre got=%b required=0", cond_tr[5]);
        end
        exp_q.push_back(4'b0010);
`ifndef DEC_TEST_SYNC_EN
        exp_q.push_back(4'b0001);
`endif
        run_word(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        run_word(4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cond_tr[7] !== 1'b1) begin
            errors++;
            $display("FAIL jcn_t_low_cond got=%b required=1", cond_tr[7]);
        end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        run_word(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fim;
        run_word(4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        run_word(4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sw_tr[7] !== 1'b1 || alu_tr !== 8'h00) begin
            errors++;
            $display("FAIL fim_word1 got=%b/%h required=1/00", sw_tr[7], alu_tr);
        end
        exp_q.push_back(4'b0010);
        run_word(4'h5, 4'hA, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sw_tr !== 8'h7F) begin
            errors++;
            $display("FAIL fim_secondword got=%h required=7f", sw_tr);
        end
        checks++;
        if (cond_tr !== 8'h00 || alu_tr !== 8'h00) begin
            errors++;
            $display("FAIL fim_ir_held got=%h/%h required=00/00", cond_tr, alu_tr);
        end
        run_word(4'h2, 4'h1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sw_tr[7] !== 1'b0) begin
            errors++;
            $display("FAIL src_one_word got=%b required=0", sw_tr[7]);
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(4'b0100);
        run_word(4'h7, 4'h3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (alu_tr !== 8'hE0) begin
            errors++;
            $display("FAIL isz_alu_enable got=%h required=e0", alu_tr);
        end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        run_word(4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b0100);
        run_word(4'h7, 4'h3, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(4'b0010);
        run_word(4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        run_word(4'h5, 4'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        run_word(4'h2, 4'h4, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b1100);
        run_word(4'hB, 4'h2, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b0100);
        run_word(4'h6, 4'h2, 1'b0, 1'b0, 1'b0);
        run_word(4'hE, 4'h9, 1'b1, 1'b1, 1'b0);
        checks++;
        if (sw_tr[7] !== 1'b0 || alu_tr !== 8'h00) begin
            errors++;
            $display("FAIL unknown_op got=%b/%h required=0/00", sw_tr[7], alu_tr);
        end
        exp_q.push_back(4'b1000);
        run_word(4'hD, 4'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (zeroFlag !== 1'b1) begin
            errors++;
            $display("FAIL ldm_zero got=%b required=1", zeroFlag);
        end
        run_word(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_carry_ops();
        test_jcn_flags();
        test_jcn_test_pin();
        test_fim();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobe_missing got=%0d required=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
